mux4_tdm_sequencer: RTL and testbench

Drives the 4:1 data-flow multiplexer as a time-division parallel-to-serial stage. It accepts a 4-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the mux select through all four slots and returns the mux output as a serial bit stream with its own valid/ready/last handshake. The block sits directly upstream of the mux and also consumes the mux output `y`.

---
 rtl/mux4_tdm_sequencer.sv | 94 +++++++++
 tb/tb_mux4_tdm_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_tdm_sequencer.sv
// Time-division parallel-to-serial stage wrapped around a 4:1 mux.
// Holds an accepted 4-bit word on the mux inputs and walks the select through all slots.
module mux4_tdm_sequencer #(
    parameter int ORDER = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [1:0] s,
    output logic [3:0] i,
    input  logic       y,
    output logic       ser_bit,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [1:0] r_s;
    logic [3:0] r_i;

    logic       w_shift;
    logic       w_cnt_last;
    logic       w_load;
    logic       w_beat;
    logic [1:0] w_cnt_next;

    // The mux decodes its index as {s[0], s[1]}, so the slot index is bit-swapped onto s.
    function automatic logic [1:0] slot_sel(input logic [1:0] cnt);
        logic [1:0] idx;
        idx = (ORDER != 0) ? (2'd3 - cnt) : cnt;
        return {idx[0], idx[1]};
    endfunction

    assign w_shift    = (r_state == SHIFT);
    assign w_cnt_last = (r_cnt == 2'd3);
    assign w_cnt_next = r_cnt + 2'd1;

    assign in_ready  = !w_shift || (w_cnt_last && ser_ready);
    assign ser_valid = w_shift;
    assign ser_last  = w_shift && w_cnt_last;
    assign ser_bit   = y;
    assign s         = r_s;
    assign i         = r_i;

    assign w_load = in_valid && in_ready;
    assign w_beat = ser_valid && ser_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_s     <= 2'b00;
            r_i     <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_i     <= in_data;
                        r_cnt   <= 2'd0;
                        r_s     <= slot_sel(2'd0);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_beat) begin
                        if (!w_cnt_last) begin
                            r_cnt <= w_cnt_next;
                            r_s   <= slot_sel(w_cnt_next);
                        end else if (w_load) begin
                            // Back-to-back word: reload without passing through IDLE.
                            r_i     <= in_data;
                            r_cnt   <= 2'd0;
                            r_s     <= slot_sel(2'd0);
                            r_state <= SHIFT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_tdm_sequencer.sv
// Directed bench for mux4_tdm_sequencer: one instance per slot order, each with its own mux model.
module tb_mux4_tdm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       ser_ready;

    logic       rdy0, rdy1, bit0, bit1, val0, val1, last0, last1;
    logic [1:0] s0, s1;
    logic [3:0] i0, i1;
    logic       y0, y1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural 4:1 mux, index = {s[0], s[1]}
    assign y0 = i0[{s0[0], s0[1]}];
    assign y1 = i1[{s1[0], s1[1]}];

    mux4_tdm_sequencer #(.ORDER(0)) u_ord0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .s(s0), .i(i0), .y(y0), .ser_bit(bit0), .ser_valid(val0),
        .ser_ready(ser_ready), .ser_last(last0)
    );

    mux4_tdm_sequencer #(.ORDER(1)) u_ord1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .s(s1), .i(i1), .y(y1), .ser_bit(bit1), .ser_valid(val1),
        .ser_ready(ser_ready), .ser_last(last1)
    );

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       rdy;
        logic [3:0] ei;
        logic [1:0] es0;
        logic       eb0;
        logic [1:0] es1;
        logic       eb1;
        logic       ev;
        logic       el;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_common(input string tag, input logic [3:0] ei, input logic ev,
                              input logic el, input logic er);
        chk({tag, " i0"}, i0, ei);
        chk({tag, " i1"}, i1, ei);
        chk({tag, " valid0"}, val0, ev);
        chk({tag, " valid1"}, val1, ev);
        chk({tag, " last0"}, last0, el);
        chk({tag, " last1"}, last1, el);
        chk({tag, " in_ready0"}, rdy0, er);
        chk({tag, " in_ready1"}, rdy1, er);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 iv  d        rdy   ei       es0    eb0   es1    eb1   ev    el    er
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 4'b1011, 1'b1, 4'b0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b1011, 2'b00, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b1011, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b1011, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b1011, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b1011, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 4'b0001, 1'b1, 4'b1011, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0001, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0001, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0001, 2'b01, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b1100, 1'b1, 4'b0001, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b1, 4'b1100, 1'b1, 4'b1100, 2'b00, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b1100, 1'b1, 4'b1100, 2'b10, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b1100, 1'b1, 4'b1100, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b1, 4'b1100, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b1, 4'b0011, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b1, 4'b0011, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b1, 4'b0011, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0011, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0011, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 4'b0110, 1'b1, 4'b0011, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0110, 2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b0, 4'b0110, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b0, 4'b0110, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b0, 4'b0110, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0110, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0110, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0110, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 4'b0110, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        ser_ready = 1'b1;
        #1;
        chk("rst s0", s0, 0);
        chk("rst s1", s1, 0);
        chk_common("rst", 4'b0000, 1'b0, 1'b0, 1'b1);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Table-driven section: inputs applied 1 time unit after the edge, outputs checked mid-cycle
        for (int k = 0; k < tbl.size(); k++) begin
            string tag;
            tag       = $sformatf("vec%0d", k);
            in_valid  = tbl[k].iv;
            in_data   = tbl[k].d;
            ser_ready = tbl[k].rdy;
            @(negedge clk);
            chk({tag, " s0"}, s0, tbl[k].es0);
            chk({tag, " bit0"}, bit0, tbl[k].eb0);
            chk({tag, " s1"}, s1, tbl[k].es1);
            chk({tag, " bit1"}, bit1, tbl[k].eb1);
            chk_common(tag, tbl[k].ei, tbl[k].ev, tbl[k].el, tbl[k].er);
            next_cycle();
        end

        // No acceptance without in_valid
        in_valid  = 1'b0;
        in_data   = 4'b1111;
        ser_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("idle%0d s0", k), s0, 2'b11);
            chk($sformatf("idle%0d s1", k), s1, 2'b00);
            chk($sformatf("idle%0d i0", k), i0, 4'b0110);
            chk($sformatf("idle%0d valid0", k), val0, 0);
            next_cycle();
        end

        // Reset asserted asynchronously during slot 2 of 1111
        in_valid = 1'b1;
        in_data  = 4'b1111;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        chk("pre-rst s0 slot2", s0, 2'b01);
        chk("pre-rst valid0", val0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async-rst s0", s0, 0);
        chk("async-rst s1", s1, 0);
        chk_common("async-rst", 4'b0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        chk("post-rst valid0", val0, 0);
        chk("post-rst valid1", val1, 0);

        // Fresh word 0101, with a stall on the last beat while a new word waits
        in_valid = 1'b1;
        in_data  = 4'b0101;
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp0, exp1;
            exp0 = 4'b0101;  // ORDER=0 bits i[0..3] = 1,0,1,0
            exp1 = 4'b1010;  // ORDER=1 bits i[3..0] = 0,1,0,1
            if (k == 3) begin
                in_valid  = 1'b1;
                in_data   = 4'b1001;
                ser_ready = 1'b0;
                #1;
                chk("stall-last in_ready0", rdy0, 0);
                chk("stall-last last0", last0, 1);
                next_cycle();
                chk("stall-last hold s0", s0, 2'b11);
                chk("stall-last hold i0", i0, 4'b0101);
                ser_ready = 1'b1;
                #1;
                chk("stall-release in_ready0", rdy0, 1);
            end
            chk($sformatf("w0101 beat%0d valid0", k), val0, 1);
            chk($sformatf("w0101 beat%0d bit0", k), bit0, exp0[k]);
            chk($sformatf("w0101 beat%0d bit1", k), bit1, exp1[k]);
            chk($sformatf("w0101 beat%0d last0", k), last0, (k == 3) ? 1 : 0);
            next_cycle();
        end
        in_valid = 1'b0;
        chk("reload i0", i0, 4'b1001);
        chk("reload s0", s0, 2'b00);
        chk("reload bit0", bit0, 1);
        chk("reload valid0", val0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
